// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encodings, mux selects and output decode for the GCD control unit
package gcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CMP  = 3'd2,
    ST_SUBA = 3'd3,
    ST_SUBB = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  localparam logic SEL_EXT  = 1'b0;
  localparam logic SEL_DIFF = 1'b1;

  typedef struct packed {
    logic aload;
    logic bload;
    logic asel;
    logic bsel;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  // Moore decode; anything unlisted (IDLE, illegal codes) drives all zeros
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_LOAD: begin
        c.aload = 1'b1;
        c.bload = 1'b1;
        c.asel  = SEL_EXT;
        c.bsel  = SEL_EXT;
        c.busy  = 1'b1;
      end
      ST_CMP:  c.busy = 1'b1;
      ST_SUBA: begin
        c.aload = 1'b1;
        c.asel  = SEL_DIFF;
        c.busy  = 1'b1;
      end
      ST_SUBB: begin
        c.bload = 1'b1;
        c.bsel  = SEL_DIFF;
        c.busy  = 1'b1;
      end
      ST_DONE: c.done = 1'b1;
      ST_ERR:  c.err  = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gcd_iter_cnt.sv
// rtl/gcd_iter_cnt.sv - saturating subtraction-step counter with clear and limit flag
module gcd_iter_cnt
  import gcd_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int MAX_VAL = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == LIMIT);

endmodule

// File: rtl/gcd_ctrl.sv
// rtl/gcd_ctrl.sv - FSM sequencing the subtract-compare GCD datapath with a go/done/err handshake
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             a_eq_b,
  input  logic             a_lt_b,
  input  logic             a_zero,
  input  logic             b_zero,
  output logic             Aload,
  output logic             Bload,
  output logic             Asel,
  output logic             Bsel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   at_max;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_CMP;
      ST_CMP: begin
        if (a_zero || b_zero)  state_d = ST_ERR;
        else if (a_eq_b)       state_d = ST_DONE;
        else if (at_max)       state_d = ST_ERR;
        else if (a_lt_b)       state_d = ST_SUBB;
        else                   state_d = ST_SUBA;
      end
      ST_SUBA, ST_SUBB: state_d = ST_CMP;
      ST_DONE, ST_ERR: if (!go) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs are registered from the next state so they always match state_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  gcd_iter_cnt #(
    .CNT_W  (CNT_W),
    .MAX_VAL(MAX_ITER)
  ) u_iter_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (state_q == ST_LOAD),
    .inc_i   ((state_q == ST_SUBA) || (state_q == ST_SUBB)),
    .cnt_o   (iter_cnt),
    .at_max_o(at_max)
  );

  assign Aload = ctrl_q.aload;
  assign Bload = ctrl_q.bload;
  assign Asel  = ctrl_q.asel;
  assign Bsel  = ctrl_q.bsel;
  assign busy  = ctrl_q.busy;
  assign done  = ctrl_q.done;
  assign err   = ctrl_q.err;

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb/tb_gcd_ctrl.sv - scoreboard bench for gcd_ctrl driving two instances (MAX_ITER 255 and 3)
module tb_gcd_ctrl;
  import gcd_pkg::*;

  logic clk;
  logic reset;
  logic [1:0] go, aload, bload, asel, bsel, busy, done, err;
  logic [1:0] a_eq_b, a_lt_b, a_zero, b_zero;
  logic [1:0][7:0] ext_a, ext_b, a_out, b_out, iter_cnt;

  typedef struct {
    bit   is_err;
    logic [7:0] gcd;
    int   iter;
    int   lat;
    int   na;
    int   nb;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [7:0] ra, rb;

    // datapath model: operand registers capture on negedge
    always @(negedge clk) begin
      if (aload[g]) ra <= (asel[g] == SEL_DIFF) ? ra - rb : ext_a[g];
      if (bload[g]) rb <= (bsel[g] == SEL_DIFF) ? rb - ra : ext_b[g];
    end

    assign a_out[g]  = ra;
    assign b_out[g]  = rb;
    assign a_eq_b[g] = (ra == rb);
    assign a_lt_b[g] = (ra < rb);
    assign a_zero[g] = (ra == 8'd0);
    assign b_zero[g] = (rb == 8'd0);

    gcd_ctrl #(
      .CNT_W   (8),
      .MAX_ITER((g == 0) ? 255 : 3)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .go      (go[g]),
      .a_eq_b  (a_eq_b[g]),
      .a_lt_b  (a_lt_b[g]),
      .a_zero  (a_zero[g]),
      .b_zero  (b_zero[g]),
      .Aload   (aload[g]),
      .Bload   (bload[g]),
      .Asel    (asel[g]),
      .Bsel    (bsel[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .err     (err[g]),
      .iter_cnt(iter_cnt[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [6:0] outs(input int g);
    return {aload[g], bload[g], asel[g], bsel[g], busy[g], done[g], err[g]};
  endfunction

  function automatic exp_t model(input logic [7:0] a_in, input logic [7:0] b_in, input int max_iter);
    exp_t e;
    logic [7:0] a, b;
    a = a_in;
    b = b_in;
    e.is_err = 1'b0;
    e.gcd = 8'd0;
    e.iter = 0;
    e.na = 1;
    e.nb = 1;
    if (a == 8'd0 || b == 8'd0) begin
      e.is_err = 1'b1;
    end else begin
      while (1) begin
        if (a == b) begin
          e.gcd = a;
          break;
        end
        if (e.iter == max_iter) begin
          e.is_err = 1'b1;
          break;
        end
        if (a < b) begin
          b = b - a;
          e.nb++;
        end else begin
          a = a - b;
          e.na++;
        end
        e.iter++;
      end
    end
    e.lat = 3 + 2 * e.iter;
    return e;
  endfunction

  task automatic run(input int g, input logic [7:0] a, input logic [7:0] b, input int hold);
    exp_t e;
    int cyc, na, nb;
    logic [7:0] it2;
    bit viol, timeout;
    sb.push_back(model(a, b, (g == 0) ? 255 : 3));
    @(negedge clk);
    ext_a[g] = a;
    ext_b[g] = b;
    go[g] = 1'b1;
    cyc = 0; na = 0; nb = 0; it2 = 8'hff; viol = 0; timeout = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (aload[g]) na++;
      if (bload[g]) nb++;
      if (cyc == 2) it2 = iter_cnt[g];
      if ((asel[g] && !aload[g]) || (bsel[g] && !bload[g]) ||
          (done[g] && err[g]) || ((done[g] || err[g]) && busy[g]) ||
          (aload[g] && bload[g] && (asel[g] || bsel[g] || !busy[g])))
        viol = 1;
      if (done[g] || err[g]) break;
      if (cyc >= 2000) begin
        timeout = 1;
        break;
      end
    end
    e = sb.pop_front();
    check("timeout", 32'(timeout), 0);
    if (!timeout) begin
      check("latency", cyc, e.lat);
      check("done", 32'(done[g]), 32'(!e.is_err));
      check("err", 32'(err[g]), 32'(e.is_err));
      check("iter_cnt", 32'(iter_cnt[g]), 32'(e.iter));
      check("aload_cnt", na, e.na);
      check("bload_cnt", nb, e.nb);
      check("iter_clr", 32'(it2), 0);
      check("invariant", 32'(viol), 0);
      if (!e.is_err) check("gcd", 32'(a_out[g]), 32'(e.gcd));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold", 32'({done[g], err[g], busy[g]}), 32'({!e.is_err, e.is_err, 1'b0}));
    end
    @(negedge clk);
    go[g] = 1'b0;
    @(posedge clk);
    #1;
    check("idle_outs", 32'(outs(g)), 0);
    check("iter_held", 32'(iter_cnt[g]), 32'(e.iter));
  endtask

  initial begin
    bit bad;
    reset = 1'b1;
    go = '0;
    ext_a = '0;
    ext_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs0", 32'(outs(0)), 0);
    check("rst_outs1", 32'(outs(1)), 0);
    check("rst_iter0", 32'(iter_cnt[0]), 0);
    @(negedge clk);
    reset = 1'b0;

    run(0, 8'd12, 8'd8, 0);
    run(0, 8'd9, 8'd9, 0);
    run(0, 8'd0, 8'd5, 0);
    run(0, 8'd5, 8'd0, 0);
    run(0, 8'd12, 8'd8, 3);
    run(0, 8'd9, 8'd9, 0);
    run(0, 8'd255, 8'd1, 0);
    run(0, 8'd1, 8'd200, 0);
    for (int i = 0; i < 6; i++)
      run(0, 8'($urandom_range(1, 90)), 8'($urandom_range(1, 90)), i % 2);
    run(1, 8'd200, 8'd1, 0);
    run(1, 8'd12, 8'd8, 0);
    run(1, 8'd7, 8'd4, 2);
    run(1, 8'd6, 8'd6, 0);

    // reset asserted during SUBA of a 12/8 run
    @(negedge clk);
    ext_a[0] = 8'd12;
    ext_b[0] = 8'd8;
    go[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_suba", 32'({aload[0], asel[0], bload[0]}), 32'(3'b110));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_outs", 32'(outs(0)), 0);
    check("async_rst_iter", 32'(iter_cnt[0]), 0);
    @(negedge clk);
    go[0] = 1'b0;
    reset = 1'b0;
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (outs(0) != 7'd0) bad = 1;
    end
    check("post_rst_idle", 32'(bad), 0);
    run(0, 8'd12, 8'd8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
Control unit for the 8-bit subtract-compare GCD datapath. It drives the load enables and mux selects of the A and B operand registers, which capture on negedge clk. It consumes comparator status fed back from the datapath and reports completion or error to the host through a level handshake on go/done/err. The FSM advances on posedge clk, so every control output is stable half a cycle before the registers sample it.

Parameters:
CNT_W, 8, width of the subtraction iteration counter
MAX_ITER, 255, subtraction steps allowed before the ERR state is forced; must be < 2**CNT_W

Ports:
clk  input  1  system clock; FSM and counter update on posedge
reset  input  1  asynchronous, active-high; forces IDLE
go  input  1  host request, level; sampled on posedge
a_eq_b  input  1  datapath status: A_out == B_out
a_lt_b  input  1  datapath status: A_out < B_out
a_zero  input  1  datapath status: A_out == 0
b_zero  input  1  datapath status: B_out == 0
Aload  output  1  A register load enable
Bload  output  1  B register load enable
Asel  output  1  A mux select: 0 = external operand, 1 = A-B
Bsel  output  1  B mux select: 0 = external operand, 1 = B-A
busy  output  1  high in LOAD, CMP, SUBA, SUBB
done  output  1  result valid; A_out holds the GCD
err  output  1  zero operand or iteration timeout
iter_cnt  output  CNT_W  number of subtraction steps in the current or last run

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, iter_cnt=0. All control and status outputs are 0.
- Output style: Moore outputs, decoded from the state register only. No output depends combinationally on any input.
- IDLE: all outputs 0. If go=1 -> LOAD.
- LOAD: Aload=Bload=1, Asel=Bsel=0. Clear iter_cnt. Next state is always CMP.
- CMP: no loads. Next state is chosen by this priority:
  - a_zero or b_zero -> ERR
  - a_eq_b -> DONE
  - iter_cnt==MAX_ITER -> ERR
  - a_lt_b -> SUBB
  - otherwise -> SUBA
- SUBA: Aload=1, Asel=1. iter_cnt+1. Next state CMP.
- SUBB: Bload=1, Bsel=1. iter_cnt+1. Next state CMP.
- iter_cnt saturates at 2**CNT_W-1. It is never cleared except by LOAD or reset, so it holds its value through DONE, ERR and IDLE.
- DONE: done=1. Remain while go=1; go=0 -> IDLE. A held go never restarts a run; the host must drop go and raise it again.
- ERR: err=1. Same exit rule as DONE.
- go is ignored in all states other than IDLE, DONE and ERR. Deasserting go mid-run does not abort the run.
- Status inputs are sampled only in CMP. Values in other states are don't-care.
- Latency: 3 + 2*N posedges from sampling go to done=1, where N is the final iter_cnt.
- Reset mid-operation: returns to IDLE immediately and clears outputs. Any partial load already captured by the datapath is irrelevant.
- Illegal state encodings -> IDLE on the next posedge.
- Invariants:
  - Aload and Bload are both high only in LOAD.
  - Asel=1 only together with Aload=1; Bsel=1 only together with Bload=1.
  - done and err are never high together, and never high together with busy.

Decomposition:
- Shared package gcd_pkg: state encodings (IDLE, LOAD, CMP, SUBA, SUBB, DONE, ERR as 3-bit constants) and the mux-select constants SEL_EXT=0, SEL_DIFF=1. The datapath uses the same constants.
- One sub-module, gcd_iter_cnt: CNT_W-bit saturating counter with clr, inc and at_max outputs, on the same clk and reset.

Test Plan:
- Reset then go with A=12, B=8 from a datapath model -> state sequence LOAD, CMP, SUBA, CMP, SUBB, CMP, DONE. done=1 after the 7th posedge, A=4, iter_cnt=2.
- A=9, B=9 -> LOAD, CMP, DONE. done after 3 posedges, iter_cnt=0, Aload/Bload pulse exactly once.
- A=0, B=5 -> ERR after 3 posedges, err=1, done=0, no SUBA/SUBB cycles.
- MAX_ITER=3, A=200, B=1 -> err=1 with iter_cnt=3, no further loads after the 3rd SUBA.
- go held high through DONE -> stays in DONE. Drop go -> IDLE next posedge. Raise go -> new LOAD, iter_cnt cleared.
- Assert reset during SUBA of the 12/8 run -> all outputs 0 asynchronously, before the next edge. After release, state is IDLE and no load is issued until go.
